uart_tx_merge: RTL and testbench

//  Byte-level merge of the two SoC serial transmit streams onto the single board UART pin.
//  - Inputs: debug-bridge TXD and SoC UART TXD. Both are 8N1 at the same baud.
//  - Each input is deserialised into its own FIFO.
//  - The FIFOs are re-serialised onto one line with fixed priority.
//  - Replaces the bitwise AND combine in front of uart_rxd_o, which corrupts overlapping frames.

---
 rtl/uart_tx_merge.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_uart_tx_merge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_merge.sv
// rtl/uart_tx_merge.sv - byte-level merge of two 8N1 serial streams onto one UART line
//
// Purpose: deserialises dbg_txd_i and uart_txd_i into one FIFO each and
//   re-serialises them onto txd_o. The debug bridge wins when both hold data;
//   arbitration happens only between frames, so output frames never interleave.
// Ports:
//   clk_i             single system clock
//   rst_ni            asynchronous active-low reset
//   dbg_txd_i         source 0 serial input (debug bridge), async, idle high
//   uart_txd_i        source 1 serial input (SoC UART), async, idle high
//   txd_o             merged 8N1 output, registered, idle high
//   busy_o            frame in flight or any FIFO non-empty
//   ovf_o[1:0]        sticky per-source FIFO overflow, [0]=dbg, [1]=uart
//   ferr_o[1:0]       one-cycle framing-error pulse per source
//   drop_cnt_o[15:0]  saturating count of lost bytes
// Build option: define UART_MERGE_DROP_CNT_EN to implement drop_cnt_o;
//   otherwise the counter is absent and drop_cnt_o reads 16'h0000.
module uart_tx_merge #(
  parameter int CLK_FREQ   = 48000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dbg_txd_i,
  input  logic        uart_txd_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic [1:0]  ovf_o,
  output logic [1:0]  ferr_o,
  output logic [15:0] drop_cnt_o
);

  localparam int BIT_CYC = CLK_FREQ / BAUDRATE;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_FULL  = CW'(BIT_CYC);
  localparam logic [CW-1:0] CNT_HALF  = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Two-flop synchronisers; reset to the idle (high) line level.
  logic [1:0] sync_q [2];
  logic [1:0] line;
  assign line = {sync_q[1][1], sync_q[0][1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q[0] <= 2'b11;
      sync_q[1] <= 2'b11;
    end else begin
      sync_q[0] <= {sync_q[0][0], dbg_txd_i};
      sync_q[1] <= {sync_q[1][0], uart_txd_i};
    end
  end

  // Receivers. The counter is loaded with N and the event fires when it
  // reads 1, i.e. N cycles after the load; the half load centres sampling.
  rx_state_t     rx_state_q [2], rx_state_d [2];
  logic [CW-1:0] rx_cnt_q [2], rx_cnt_d [2];
  logic [2:0]    rx_bit_q [2], rx_bit_d [2];
  logic [7:0]    rx_sh_q [2], rx_sh_d [2];
  logic [1:0]    rx_push, rx_ferr;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rx_state_d[s] = rx_state_q[s];
      rx_cnt_d[s]   = rx_cnt_q[s];
      rx_bit_d[s]   = rx_bit_q[s];
      rx_sh_d[s]    = rx_sh_q[s];
      rx_push[s]    = 1'b0;
      rx_ferr[s]    = 1'b0;
      case (rx_state_q[s])
        RX_IDLE: begin
          if (!line[s]) begin
            rx_state_d[s] = RX_START;
            rx_cnt_d[s]   = CNT_HALF;
          end
        end
        RX_START: begin
          if (rx_cnt_q[s] == CNT_ONE) begin
            if (line[s]) begin
              rx_state_d[s] = RX_IDLE;
            end else begin
              rx_state_d[s] = RX_DATA;
              rx_bit_d[s]   = 3'd0;
              rx_cnt_d[s]   = CNT_FULL;
            end
          end else begin
            rx_cnt_d[s] = rx_cnt_q[s] - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q[s] == CNT_ONE) begin
            rx_sh_d[s]  = {line[s], rx_sh_q[s][7:1]};
            rx_cnt_d[s] = CNT_FULL;
            if (rx_bit_q[s] == 3'd7) rx_state_d[s] = RX_STOP;
            else                     rx_bit_d[s]   = rx_bit_q[s] + 3'd1;
          end else begin
            rx_cnt_d[s] = rx_cnt_q[s] - CNT_ONE;
          end
        end
        RX_STOP: begin
          // Returning to IDLE at mid stop bit leaves half a bit to catch
          // the next start edge of a back-to-back frame.
          if (rx_cnt_q[s] == CNT_ONE) begin
            if (line[s]) begin
              rx_push[s]    = 1'b1;
              rx_state_d[s] = RX_IDLE;
            end else begin
              rx_ferr[s]    = 1'b1;
              rx_state_d[s] = RX_BRK;
            end
          end else begin
            rx_cnt_d[s] = rx_cnt_q[s] - CNT_ONE;
          end
        end
        RX_BRK: begin
          if (line[s]) rx_state_d[s] = RX_IDLE;
        end
        default: rx_state_d[s] = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < 2; s++) begin
        rx_state_q[s] <= RX_IDLE;
        rx_cnt_q[s]   <= '0;
        rx_bit_q[s]   <= '0;
        rx_sh_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        rx_state_q[s] <= rx_state_d[s];
        rx_cnt_q[s]   <= rx_cnt_d[s];
        rx_bit_q[s]   <= rx_bit_d[s];
        rx_sh_q[s]    <= rx_sh_d[s];
      end
    end
  end

  // Per-source FIFOs.
  logic [7:0]    fifo_mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [2], rd_ptr_q [2];
  logic [AW:0]   fifo_cnt_q [2];
  logic [1:0]    empty, full, push_ok, drop, pop;
  logic [7:0]    head [2];
  logic [1:0]    ovf_q, ferr_q;

  assign empty[0] = (fifo_cnt_q[0] == '0);
  assign empty[1] = (fifo_cnt_q[1] == '0);
  assign full[0]  = (fifo_cnt_q[0] == FIFO_FULL);
  assign full[1]  = (fifo_cnt_q[1] == FIFO_FULL);
  assign head[0]  = fifo_mem[0][rd_ptr_q[0]];
  assign head[1]  = fifo_mem[1][rd_ptr_q[1]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      push_ok[s] = rx_push[s] & (~full[s] | pop[s]);
      drop[s]    = rx_push[s] & full[s] & ~pop[s];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 2; s++) begin
      if (push_ok[s]) fifo_mem[s][wr_ptr_q[s]] <= rx_sh_q[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s]   <= '0;
        rd_ptr_q[s]   <= '0;
        fifo_cnt_q[s] <= '0;
      end
      ovf_q  <= 2'b00;
      ferr_q <= 2'b00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push_ok[s]) wr_ptr_q[s] <= wr_ptr_q[s] + AW'(1);
        if (pop[s])     rd_ptr_q[s] <= rd_ptr_q[s] + AW'(1);
        case ({push_ok[s], pop[s]})
          2'b10:   fifo_cnt_q[s] <= fifo_cnt_q[s] + (AW+1)'(1);
          2'b01:   fifo_cnt_q[s] <= fifo_cnt_q[s] - (AW+1)'(1);
          default: fifo_cnt_q[s] <= fifo_cnt_q[s];
        endcase
      end
      ovf_q  <= ovf_q | drop;
      ferr_q <= rx_ferr;
    end
  end

  // Transmitter. txd is produced by the next-state logic and registered,
  // so the line changes on the same edge as the state.
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    pop        = 2'b00;
    case (tx_state_q)
      TX_IDLE: begin
        if (!empty[0] || !empty[1]) begin
          if (!empty[0]) begin
            pop[0]  = 1'b1;
            tx_sh_d = head[0];
          end else begin
            pop[1]  = 1'b1;
            tx_sh_d = head[1];
          end
          tx_state_d = TX_START;
          tx_cnt_d   = CNT_FULL;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_ONE) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_ONE) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_ONE) tx_state_d = TX_IDLE;
        else                     tx_cnt_d   = tx_cnt_q - CNT_ONE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

`ifdef UART_MERGE_DROP_CNT_EN
  // A source cannot overflow and framing-fail in the same cycle, so each
  // source contributes at most one lost byte per cycle.
  logic [15:0] drop_cnt_q;
  logic [1:0]  lost;
  logic [16:0] drop_sum;
  assign lost     = drop | rx_ferr;
  assign drop_sum = {1'b0, drop_cnt_q} + 17'(lost[0]) + 17'(lost[1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= 16'h0000;
    else         drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 16'h0000;
`endif

  assign txd_o  = txd_q;
  assign busy_o = (tx_state_q != TX_IDLE) || (empty != 2'b11);
  assign ovf_o  = ovf_q;
  assign ferr_o = ferr_q;

endmodule

// File: tb/tb_uart_tx_merge.sv
// tb/tb_uart_tx_merge.sv - directed self-checking bench for uart_tx_merge
module tb_uart_tx_merge;

  localparam int BIT = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg_txd = 1'b1;
  logic        uart_txd = 1'b1;
  logic        txd;
  logic        busy;
  logic [1:0]  ovf;
  logic [1:0]  ferr;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_start [2];
  int ferr_cnt [2] = '{0, 0};
  logic [7:0] byte_q [$];
  logic       stop_q [$];
  int         start_q [$];
  logic       prev_txd = 1'b1;

`ifdef UART_MERGE_DROP_CNT_EN
  localparam logic [15:0] DROP_T4 = 16'd4;
  localparam logic [15:0] DROP_T5 = 16'd5;
`else
  localparam logic [15:0] DROP_T4 = 16'd0;
  localparam logic [15:0] DROP_T5 = 16'd0;
`endif

  uart_tx_merge #(
    .CLK_FREQ  (48000000),
    .BAUDRATE  (1000000),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .dbg_txd_i (dbg_txd),
    .uart_txd_i(uart_txd),
    .txd_o     (txd),
    .busy_o    (busy),
    .ovf_o     (ovf),
    .ferr_o    (ferr),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ferr[0]) ferr_cnt[0] <= ferr_cnt[0] + 1;
    if (ferr[1]) ferr_cnt[1] <= ferr_cnt[1] + 1;
  end

  // Output frame capture: sample each bit at its centre.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (prev_txd && !txd) begin
        start_q.push_back(cyc);
        repeat (BIT / 2) @(negedge clk);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        byte_q.push_back(b);
        stop_q.push_back(txd);
      end
      prev_txd = txd;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int src, input logic v);
    if (src == 0) dbg_txd = v;
    else          uart_txd = v;
  endtask

  // Sends n back-to-back frames carrying base, base+1, ...
  task automatic send_burst(input int src, input logic [7:0] base, input int n);
    logic [9:0] fr;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      fr = {1'b1, base + 8'(k), 1'b0};
      for (int i = 0; i < 10; i++) begin
        drive(src, fr[i]);
        if (k == 0 && i == 0) src_start[src] = cyc;
        repeat (BIT) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, byte_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic clear_capture();
    byte_q.delete();
    stop_q.delete();
    start_q.delete();
  endtask

  initial begin
    int lat;
    int s;
    int k;
    int f0;
    int f1;

    // 1: reset state, and stays quiet after release
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ovf", ovf, 2'b00);
    check_eq("rst_ferr", ferr, 2'b00);
    check_eq("rst_drop", drop_cnt, 16'h0000);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_eq("post_rst_txd", txd, 1'b1);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_ovf", ovf, 2'b00);
    check_eq("post_rst_drop", drop_cnt, 16'h0000);
    check_eq("post_rst_frames", start_q.size(), 0);

    // 2: single dbg byte, latency bound
    clear_capture();
    send_burst(0, 8'h55, 1);
    wait_bytes(1, 1000, "t2_count");
    check_eq("t2_byte", byte_q[0], 8'h55);
    check_eq("t2_stop", stop_q[0], 1'b1);
    lat = start_q[0] - src_start[0];
    check_eq("t2_lat_max", (lat <= 460), 1'b1);
    check_eq("t2_lat_min", (lat >= 456), 1'b1);
    wait_idle(200, "t2_idle");

    // 3: simultaneous bytes, dbg first, one-cycle gap
    clear_capture();
    fork
      send_burst(0, 8'hA5, 1);
      send_burst(1, 8'h3C, 1);
    join
    wait_bytes(2, 1500, "t3_count");
    check_eq("t3_byte0", byte_q[0], 8'hA5);
    check_eq("t3_byte1", byte_q[1], 8'h3C);
    check_eq("t3_stop1", stop_q[1], 1'b1);
    check_eq("t3_start_spacing", start_q[1] - start_q[0], 10 * BIT + 1);
    check_eq("t3_ovf", ovf, 2'b00);
    wait_idle(200, "t3_idle");

    // 4: 20 bytes per source, uart overflows
    clear_capture();
    fork
      send_burst(0, 8'h80, 20);
      send_burst(1, 8'h00, 20);
    join
    wait_bytes(36, 12000, "t4_count");
    for (int i = 0; i < 20; i++) check_eq($sformatf("t4_dbg%0d", i), byte_q[i], 8'h80 + 8'(i));
    for (int i = 0; i < 16; i++) check_eq($sformatf("t4_uart%0d", i), byte_q[20 + i], 8'(i));
    check_eq("t4_ovf", ovf, 2'b10);
    check_eq("t4_drop", drop_cnt, DROP_T4);
    repeat (1000) @(posedge clk);
    check_eq("t4_no_extra", byte_q.size(), 36);
    wait_idle(200, "t4_idle");

    // 5: break on uart, then a clean byte
    clear_capture();
    f0 = ferr_cnt[0];
    f1 = ferr_cnt[1];
    @(posedge clk);
    #1;
    uart_txd = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1;
    uart_txd = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    check_eq("t5_break_no_byte", start_q.size(), 0);
    send_burst(1, 8'h81, 1);
    wait_bytes(1, 1000, "t5_count");
    check_eq("t5_byte", byte_q[0], 8'h81);
    check_eq("t5_stop", stop_q[0], 1'b1);
    check_eq("t5_ferr1_pulses", ferr_cnt[1] - f1, 1);
    check_eq("t5_ferr0_pulses", ferr_cnt[0] - f0, 0);
    check_eq("t5_drop", drop_cnt, DROP_T5);
    check_eq("t5_ovf", ovf, 2'b10);
    wait_idle(200, "t5_idle");

    // 6: async reset in the middle of TX data bit 3
    clear_capture();
    fork
      send_burst(0, 8'h07, 1);
      send_burst(1, 8'h99, 1);
    join
    k = 0;
    while (start_q.size() < 1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_tx_started", start_q.size(), 1);
    s = (start_q.size() > 0) ? start_q[0] : cyc;
    k = 0;
    while (cyc < s + 4 * BIT + 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_bit3_low", txd, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_txd", txd, 1'b1);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_ovf", ovf, 2'b00);
    check_eq("t6_rst_drop", drop_cnt, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    check_eq("t6_no_residual", start_q.size(), 1);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_txd_idle", txd, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
